phase_scheduler: RTL and testbench

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/phase_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_phase_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// phase_scheduler
// Two-approach traffic-light phase sequencer with demand-actuated greens,
// fixed yellow / all-red clearance and an optional pedestrian walk phase.
//
// Optional feature: define PED_WALK_EN to build the WALK phase and the
// pedestrian request latch. Without it ped_req is ignored, walk and ped_ack
// are tied low and the WALK state is never entered.
//
// Ports
//   clk          rising-edge clock
//   CLR          asynchronous active-low reset
//   en           run enable; low freezes state, counter and demand flags
//   car_ns       north-south vehicle sensor (level)
//   car_ew       east-west vehicle sensor (level)
//   ped_req      pedestrian button (pulse or level)
//   NR/NY/NG     north-south red / yellow / green lamps
//   ER/EY/EG     east-west red / yellow / green lamps
//   walk         pedestrian walk lamp
//   ped_ack      one-cycle pulse when a pedestrian request is first latched
//   phase        current state code (AR=0 NSG=1 NSY=2 EWG=3 EWY=4 WALK=5)
module phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       CLR,
  input  logic       en,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic       NR,
  output logic       NY,
  output logic       NG,
  output logic       ER,
  output logic       EY,
  output logic       EG,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_AR   = 3'd0,
    S_NSG  = 3'd1,
    S_NSY  = 3'd2,
    S_EWG  = 3'd3,
    S_EWY  = 3'd4,
    S_WALK = 3'd5
  } state_t;

  // Counter values on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dem_ns;
  logic             dem_ew;
  logic             ped_pend;
  logic             next_ew;
  logic             from_yellow;
  logic             entering;
  logic             opp_ns;
  logic             opp_ew;

  assign phase    = state;
  assign entering = (state_nxt != state);
  assign opp_ns   = dem_ew | ped_pend;
  assign opp_ew   = dem_ns | ped_pend;

  // Next-state logic. Timed states leave after their last counted cycle;
  // greens only leave when the other side (or a pedestrian) is waiting.
  // Unused codes fall back to all-red even while disabled.
  always_comb begin
    state_nxt = state;
    case (state)
      S_AR: begin
        if (en && cnt >= ALLRED_LAST) begin
          if (ped_pend && from_yellow) state_nxt = S_WALK;
          else if (next_ew)            state_nxt = S_EWG;
          else                         state_nxt = S_NSG;
        end
      end
      S_NSG: begin
        if (en && opp_ns && ((cnt >= GMIN_LAST && !car_ns) || cnt >= GMAX_LAST))
          state_nxt = S_NSY;
      end
      S_NSY: begin
        if (en && cnt >= YEL_LAST) state_nxt = S_AR;
      end
      S_EWG: begin
        if (en && opp_ew && ((cnt >= GMIN_LAST && !car_ew) || cnt >= GMAX_LAST))
          state_nxt = S_EWY;
      end
      S_EWY: begin
        if (en && cnt >= YEL_LAST) state_nxt = S_AR;
      end
      S_WALK: begin
        if (en && cnt >= WALK_LAST) state_nxt = S_AR;
      end
      default: state_nxt = S_AR;
    endcase
  end

  // State register, phase counter and registered lamp decode. Lamps are
  // decoded from the next state so they change on the same edge as phase.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state <= S_AR;
      cnt   <= '0;
      NR    <= 1'b1;
      NY    <= 1'b0;
      NG    <= 1'b0;
      ER    <= 1'b1;
      EY    <= 1'b0;
      EG    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (entering)
        cnt <= '0;
      else if (en && cnt != '1)
        cnt <= cnt + 1'b1;
      NG <= (state_nxt == S_NSG);
      NY <= (state_nxt == S_NSY);
      NR <= !((state_nxt == S_NSG) || (state_nxt == S_NSY));
      EG <= (state_nxt == S_EWG);
      EY <= (state_nxt == S_EWY);
      ER <= !((state_nxt == S_EWG) || (state_nxt == S_EWY));
    end
  end

  // Vehicle demand latches (set beats clear) plus the bookkeeping that
  // decides what follows all-red: which green is next, and whether all-red
  // was reached through a yellow (only then may a walk phase be inserted).
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      dem_ns      <= 1'b0;
      dem_ew      <= 1'b0;
      next_ew     <= 1'b0;
      from_yellow <= 1'b0;
    end else begin
      if (en) begin
        if (car_ns)
          dem_ns <= 1'b1;
        else if (entering && state_nxt == S_NSG)
          dem_ns <= 1'b0;
        if (car_ew)
          dem_ew <= 1'b1;
        else if (entering && state_nxt == S_EWG)
          dem_ew <= 1'b0;
      end
      if (entering && state == S_NSY)
        next_ew <= 1'b1;
      else if (entering && state == S_EWY)
        next_ew <= 1'b0;
      if (entering && state_nxt == S_AR)
        from_yellow <= (state == S_NSY) || (state == S_EWY);
    end
  end

`ifdef PED_WALK_EN
  // Pedestrian latch. The acknowledge pulse marks only the 0->1 edge of the
  // pending flag, so holding or re-pressing the button is silent. Presses
  // during the walk itself are dropped.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
      walk     <= 1'b0;
    end else begin
      walk    <= (state_nxt == S_WALK);
      ped_ack <= 1'b0;
      if (en) begin
        if (ped_req && state != S_WALK) begin
          ped_pend <= 1'b1;
          ped_ack  <= !ped_pend;
        end else if (entering && state_nxt == S_WALK) begin
          ped_pend <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
  assign ped_ack        = 1'b0;
  assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler
// Scoreboarded bench for phase_scheduler at default parameters. Stimulus
// pushes the expected phase/lamp/ack picture for each upcoming clock cycle;
// a monitor pops and compares on every falling edge (or immediately, for
// the asynchronous reset picture). Build with PED_WALK_EN defined to
// exercise the walk phase; otherwise pedestrian presses must be ignored.
module tb_phase_scheduler;

  localparam logic [2:0] P_AR   = 3'd0;
  localparam logic [2:0] P_NSG  = 3'd1;
  localparam logic [2:0] P_NSY  = 3'd2;
  localparam logic [2:0] P_EWG  = 3'd3;
  localparam logic [2:0] P_EWY  = 3'd4;
  localparam logic [2:0] P_WALK = 3'd5;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [5:0] lamps;
    logic       walk;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       CLR = 1'b0;
  logic       en = 1'b1;
  logic       car_ns = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic       NR, NY, NG, ER, EY, EG;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  exp_t sb[$];
  int   cyc = 0;
  int   plan_cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   c0;
  event sample_now;

  phase_scheduler dut (
    .clk     (clk),
    .CLR     (CLR),
    .en      (en),
    .car_ns  (car_ns),
    .car_ew  (car_ew),
    .ped_req (ped_req),
    .NR      (NR),
    .NY      (NY),
    .NG      (NG),
    .ER      (ER),
    .EY      (EY),
    .EG      (EG),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Cycle index: the value after the k-th rising edge describes cycle k.
  always @(posedge clk) cyc <= cyc + 1;

  // Lamp picture for a phase code: {NR,NY,NG,ER,EY,EG}.
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    logic nr, ny, ng, er, ey, eg;
    ng = (ph == P_NSG);
    ny = (ph == P_NSY);
    nr = !(ng || ny);
    eg = (ph == P_EWG);
    ey = (ph == P_EWY);
    er = !(eg || ey);
    return {nr, ny, ng, er, ey, eg};
  endfunction

  // Queue n cycles of phase ph starting at the next planned cycle; ack_at
  // selects the one cycle within the span where ped_ack must be high.
  task automatic expect_span(input logic [2:0] ph, input int n, input int ack_at = -1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc   = plan_cyc + i;
      e.ph    = ph;
      e.lamps = lamps_for(ph);
      e.walk  = (ph == P_WALK);
      e.ack   = (i == ack_at);
      sb.push_back(e);
    end
    plan_cyc += n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic applyStimulus(input logic ns, input logic ew, input logic ped);
    car_ns  = ns;
    car_ew  = ew;
    ped_req = ped;
  endtask

  // Pull CLR low between edges, check the reset picture with no clock edge,
  // then release so the next planned cycle is the first all-red cycle.
  task automatic apply_reset();
    exp_t e;
    CLR = 1'b0;
    #1;
    e.cyc   = cyc;
    e.ph    = P_AR;
    e.lamps = 6'b100100;
    e.walk  = 1'b0;
    e.ack   = 1'b0;
    sb.push_back(e);
    -> sample_now;
    step();
    step();
    CLR      = 1'b1;
    plan_cyc = cyc;
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (e.cyc != cyc) begin
      miscompares++;
      $display("[TB] FAIL stale@cyc%0d: expectation for cyc%0d never sampled (want phase=%0d)",
               cyc, e.cyc, e.ph);
    end else if (phase !== e.ph || {NR, NY, NG, ER, EY, EG} !== e.lamps ||
                 walk !== e.walk || ped_ack !== e.ack) begin
      miscompares++;
      $display("[TB] FAIL state@cyc%0d: got phase=%0d lamps=%b walk=%b ack=%b, want phase=%0d lamps=%b walk=%b ack=%b",
               cyc, phase, {NR, NY, NG, ER, EY, EG}, walk, ped_ack,
               e.ph, e.lamps, e.walk, e.ack);
    end
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    forever begin
      @(negedge clk or sample_now);
      while (sb.size() > 0 && sb[0].cyc <= cyc) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step();

    // Idle: all-red clearance, then north-south green held with no demand.
    apply_reset();
    c0 = plan_cyc;
    expect_span(P_AR, 2);
    expect_span(P_NSG, 100);
`ifndef PED_WALK_EN
    wait_until(c0 + 10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_until(c0 + 12);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif
    wait_until(plan_cyc);

    // East-west demand from green cycle 1: minimum green, yellow, all-red,
    // east-west green; then a brief north-south call hands it back.
    apply_reset();
    c0 = plan_cyc;
    expect_span(P_AR, 2);
    expect_span(P_NSG, 8);
    expect_span(P_NSY, 4);
    expect_span(P_AR, 2);
    expect_span(P_EWG, 12);
    expect_span(P_EWY, 4);
    expect_span(P_AR, 2);
    expect_span(P_NSG, 5);
    wait_until(c0 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_until(c0 + 26);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(c0 + 27);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_until(plan_cyc);

    // Both approaches busy: each green runs to its maximum.
    applyStimulus(1'b1, 1'b1, 1'b0);
    apply_reset();
    expect_span(P_AR, 2);
    expect_span(P_NSG, 32);
    expect_span(P_NSY, 4);
    expect_span(P_AR, 2);
    expect_span(P_EWG, 32);
    expect_span(P_EWY, 4);
    expect_span(P_AR, 2);
    expect_span(P_NSG, 3);
    wait_until(plan_cyc);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Freeze for 20 cycles mid-green: the remaining green time resumes.
    apply_reset();
    c0 = plan_cyc;
    expect_span(P_AR, 2);
    expect_span(P_NSG, 28);
    expect_span(P_NSY, 4);
    expect_span(P_AR, 2);
    expect_span(P_EWG, 3);
    wait_until(c0 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_until(c0 + 5);
    en = 1'b0;
    wait_until(c0 + 25);
    en = 1'b1;
    wait_until(plan_cyc);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset mid east-west yellow: immediate all-red, pending east-west
    // demand is discarded so the new north-south green does not end.
    apply_reset();
    c0 = plan_cyc;
    expect_span(P_AR, 2);
    expect_span(P_NSG, 8);
    expect_span(P_NSY, 4);
    expect_span(P_AR, 2);
    expect_span(P_EWG, 8);
    expect_span(P_EWY, 1);
    wait_until(c0 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_until(c0 + 16);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(c0 + 25);
    applyStimulus(1'b0, 1'b0, 1'b0);
    apply_reset();
    expect_span(P_AR, 2);
    expect_span(P_NSG, 12);
    wait_until(plan_cyc);

    // Pedestrian press during east-west green with north-south traffic.
    apply_reset();
    c0 = plan_cyc;
    expect_span(P_AR, 2);
    expect_span(P_NSG, 8);
    expect_span(P_NSY, 4);
    expect_span(P_AR, 2);
`ifdef PED_WALK_EN
    expect_span(P_EWG, 8, 3);
    expect_span(P_EWY, 4);
    expect_span(P_AR, 2);
    expect_span(P_WALK, 10);
    expect_span(P_AR, 2);
    expect_span(P_NSG, 3);
`else
    expect_span(P_EWG, 8);
    expect_span(P_EWY, 4);
    expect_span(P_AR, 2);
    expect_span(P_NSG, 16);
`endif
    wait_until(c0 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_until(c0 + 16);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(c0 + 18);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_until(c0 + 19);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(c0 + 21);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_until(c0 + 22);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(c0 + 32);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_until(c0 + 33);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_until(plan_cyc);
    applyStimulus(1'b0, 1'b0, 1'b0);

    step();
    step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
